// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: GF(2^8) constants, stage FSM encoding,
// default correction capacity.
package rs_pkg;

  localparam logic [7:0] GF_ALPHA           = 8'h02;
  localparam int         GF_ORDER           = 255;
  localparam int         DEFAULT_MAX_ERRORS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_SCAN,
    ST_DONE
  } chien_state_e;

endpackage

// File: rtl/finite_field_multiplier_mastravito.sv
// Combinational GF(2^8) Mastrovito multiplier; row i of reduction_matrix
// (bits [8*i +: 8]) holds x^(8+i) reduced by the field polynomial.
module finite_field_multiplier_mastravito (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [55:0] reduction_matrix,
  output logic [7:0]  product
);

  logic [14:0] raw;

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      raw = raw ^ ({7'b0, b & {8{a[i]}}} << i);
    end
    product = raw[7:0];
    for (int unsigned i = 0; i < 7; i++) begin
      if (raw[8 + i]) begin
        product = product ^ reduction_matrix[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/chien_search.sv
// Chien search over all 255 nonzero GF(2^8) elements for the roots of the
// error-locator polynomial. Optional early exit: CHIEN_EARLY_EXIT_EN.
module chien_search
  import rs_pkg::*;
#(
  parameter int MAX_ERRORS = DEFAULT_MAX_ERRORS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [8*MAX_ERRORS-1:0]       error_locator_flat,
  input  logic [56:0]                   reduction_matrix,
  output logic                          busy,
  output logic                          done,
  output logic [8*MAX_ERRORS-1:0]       roots_flat,
  output logic [$clog2(MAX_ERRORS):0]   root_count,
  output logic                          fail
);

  localparam int         RCW       = $clog2(MAX_ERRORS) + 1;
  localparam logic [8:0] INIT_LAST = 9'(MAX_ERRORS - 1);
  localparam logic [8:0] SCAN_LAST = 9'(GF_ORDER);

  chien_state_e   state, state_next;
  logic [7:0]     t      [MAX_ERRORS];
  logic [7:0]     t_next [MAX_ERRORS];
  logic [7:0]     c      [MAX_ERRORS];
  logic [7:0]     roots  [MAX_ERRORS];
  logic [7:0]     x, x_next;
  logic [7:0]     c_run, c_run_next;
  logic [8:0]     cnt;
  logic [RCW-1:0] degree, deg_comb;
  logic           any_nz_comb;
  logic           lam0_zero, all_zero;
  logic [7:0]     sum;
  logic           is_root, accept, scan_final, early_exit;
  logic [55:0]    rmat;
  logic           unused_rmat_bit;

  assign rmat            = reduction_matrix[55:0];
  assign unused_rmat_bit = reduction_matrix[56];

  for (genvar k = 0; k < MAX_ERRORS; k++) begin : g_term
    finite_field_multiplier_mastravito u_term_mul (
      .a                (t[k]),
      .b                (c[k]),
      .reduction_matrix (rmat),
      .product          (t_next[k])
    );
  end

  finite_field_multiplier_mastravito u_x_mul (
    .a                (x),
    .b                (GF_ALPHA),
    .reduction_matrix (rmat),
    .product          (x_next)
  );

  finite_field_multiplier_mastravito u_const_mul (
    .a                (c_run),
    .b                (GF_ALPHA),
    .reduction_matrix (rmat),
    .product          (c_run_next)
  );

  always_comb begin
    sum         = '0;
    deg_comb    = '0;
    any_nz_comb = 1'b0;
    for (int unsigned k = 0; k < MAX_ERRORS; k++) begin
      sum = sum ^ t[k];
      if (t[k] != 8'h00) begin
        deg_comb    = RCW'(k);
        any_nz_comb = 1'b1;
      end
    end
  end

  assign is_root = (sum == 8'h00);

`ifdef CHIEN_EARLY_EXIT_EN
  assign early_exit = (degree != '0) && (root_count == degree);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    roots_flat = '0;
    for (int unsigned k = 0; k < MAX_ERRORS; k++) begin
      roots_flat[8*k +: 8] = roots[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // The extra SCAN cycle at cnt==255 evaluates fail from the registered
  // root_count, so the last candidate's root is already counted.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    scan_final = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        if (cnt == INIT_LAST) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        scan_final = (cnt == SCAN_LAST) || early_exit;
        if (scan_final) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_INIT) || (state == ST_SCAN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < MAX_ERRORS; k++) begin
        t[k]     <= '0;
        c[k]     <= '0;
        roots[k] <= '0;
      end
      x          <= '0;
      c_run      <= '0;
      cnt        <= '0;
      degree     <= '0;
      lam0_zero  <= 1'b0;
      all_zero   <= 1'b0;
      root_count <= '0;
      fail       <= 1'b0;
    end else if (accept) begin
      for (int unsigned k = 0; k < MAX_ERRORS; k++) begin
        t[k]     <= error_locator_flat[8*k +: 8];
        c[k]     <= '0;
        roots[k] <= '0;
      end
      x          <= 8'h01;
      c_run      <= 8'h01;
      cnt        <= '0;
      degree     <= '0;
      lam0_zero  <= (error_locator_flat[7:0] == 8'h00);
      all_zero   <= 1'b0;
      root_count <= '0;
      fail       <= 1'b0;
    end else if (state == ST_INIT) begin
      // Constants enter at the top and shift down: after MAX_ERRORS cycles
      // c[k] holds alpha^k.
      for (int unsigned k = 0; k + 1 < MAX_ERRORS; k++) begin
        c[k] <= c[k + 1];
      end
      c[MAX_ERRORS - 1] <= c_run;
      c_run    <= c_run_next;
      degree   <= deg_comb;
      all_zero <= !any_nz_comb;
      cnt      <= (cnt == INIT_LAST) ? '0 : cnt + 9'd1;
    end else if (state == ST_SCAN) begin
      if (scan_final) begin
        if (lam0_zero || all_zero || (root_count != degree)) fail <= 1'b1;
      end else begin
        if (is_root) begin
          if (root_count == RCW'(MAX_ERRORS)) begin
            fail <= 1'b1;
          end else begin
            for (int unsigned r = 0; r < MAX_ERRORS; r++) begin
              if (root_count == RCW'(r)) roots[r] <= x;
            end
            root_count <= root_count + RCW'(1);
          end
        end
        for (int unsigned k = 0; k < MAX_ERRORS; k++) begin
          t[k] <= t_next[k];
        end
        x   <= x_next;
        cnt <= cnt + 9'd1;
      end
    end
  end

endmodule
